// File: rtl/seq_adder.sv
// seq_adder: multi-cycle ripple adder that sums two WIDTH-bit operands STEP
// bits per clock. One operand set is taken in IDLE, N = WIDTH/STEP edges are
// spent in RUN, and the result is held in DONE until the consumer takes it.
// flush aborts the current operation; rst_n is asynchronous and active-low.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Reject operand widths that cannot be split into whole slices.
    generate
        if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("seq_adder: STEP must be >= 1 and divide WIDTH (>= 1) exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             c_out_reg;
    logic             overflow_reg;

    logic [STEP-1:0]  slice_a;
    logic [STEP-1:0]  slice_b;
    logic [STEP:0]    slice_full;
    logic [STEP-1:0]  slice_sum;
    logic             slice_carry;
    logic             msb_carry_in;
    logic             accept;
    logic             last_step;

    // An operand set is taken only in IDLE, and never while a flush is requested.
    assign accept    = (state_reg == IDLE) && in_valid && !flush;
    assign last_step = (cnt_reg == CNT_LAST);

    // Select the current slice of each operand and add it with the running carry.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                slice_a = a_reg[i*STEP +: STEP];
                slice_b = b_reg[i*STEP +: STEP];
            end
        end
        slice_full  = {1'b0, slice_a} + {1'b0, slice_b} + {{STEP{1'b0}}, carry_reg};
        slice_sum   = slice_full[STEP-1:0];
        slice_carry = slice_full[STEP];
        // Sum bit = a ^ b ^ carry_in, so the carry entering the top bit of the
        // slice falls out of the operand and sum bits without a second chain.
        msb_carry_in = slice_a[STEP-1] ^ slice_b[STEP-1] ^ slice_sum[STEP-1];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush outranks accept, stepping and out_ready.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from registered state or taken straight from registers.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        sum       = sum_reg;
        c_out     = c_out_reg;
        overflow  = overflow_reg;
    end

    // Datapath: capture operands on accept, accumulate one slice per RUN edge,
    // and hold the result untouched until the next accept or a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            cnt_reg      <= '0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        carry_reg    <= c_in;
                        cnt_reg      <= '0;
                        sum_reg      <= '0;
                        c_out_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        sum_reg      <= '0;
                        c_out_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (cnt_reg == CNT_W'(i)) begin
                                sum_reg[i*STEP +: STEP] <= slice_sum;
                            end
                        end
                        carry_reg <= slice_carry;
                        if (last_step) begin
                            // Counter parks at N-1; only a new accept rewinds it.
                            c_out_reg    <= slice_carry;
                            overflow_reg <= slice_carry ^ msb_carry_in;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (flush) begin
                        sum_reg      <= '0;
                        c_out_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed bench for seq_adder. Four instances cover
// WIDTH=8/STEP=1, WIDTH=8/STEP=4, WIDTH=8/STEP=2 and WIDTH=1/STEP=1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] iv;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
    logic       flush;
    logic       out_ready;

    logic [3:0] ir;
    logic [3:0] ov;
    logic [3:0] co;
    logic [3:0] of;
    logic [7:0] sm [0:2];
    logic       sm1;

    int         sel;
    logic       cur_ir;
    logic       cur_ov;
    logic       cur_co;
    logic       cur_of;
    logic [7:0] cur_sum;

    int n_checks;
    int n_fail;

    seq_adder #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a8), .b(b8), .c_in(c8), .flush(flush), .out_valid(ov[0]),
        .out_ready(out_ready), .sum(sm[0]), .c_out(co[0]), .overflow(of[0])
    );

    seq_adder #(.WIDTH(8), .STEP(4)) u_w8s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a8), .b(b8), .c_in(c8), .flush(flush), .out_valid(ov[1]),
        .out_ready(out_ready), .sum(sm[1]), .c_out(co[1]), .overflow(of[1])
    );

    seq_adder #(.WIDTH(8), .STEP(2)) u_w8s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a8), .b(b8), .c_in(c8), .flush(flush), .out_valid(ov[2]),
        .out_ready(out_ready), .sum(sm[2]), .c_out(co[2]), .overflow(of[2])
    );

    seq_adder #(.WIDTH(1), .STEP(1)) u_w1s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a8[0:0]), .b(b8[0:0]), .c_in(c8), .flush(flush), .out_valid(ov[3]),
        .out_ready(out_ready), .sum(sm1), .c_out(co[3]), .overflow(of[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // View of whichever instance the current scenario is driving.
    always_comb begin
        cur_ir  = ir[sel[1:0]];
        cur_ov  = ov[sel[1:0]];
        cur_co  = co[sel[1:0]];
        cur_of  = of[sel[1:0]];
        case (sel)
            0:       cur_sum = sm[0];
            1:       cur_sum = sm[1];
            2:       cur_sum = sm[2];
            default: cur_sum = {7'b0, sm1};
        endcase
    end

    // Accept one operand set on instance w and wait (bounded) for out_valid.
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, output int lat, output logic [7:0] s,
                          output logic c, output logic o);
        sel = w;
        @(negedge clk);
        a8 = av; b8 = bv; c8 = cv; iv[w] = 1'b1;
        @(negedge clk);
        iv[w] = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!cur_ov) lat = 99;
        s = cur_sum; c = cur_co; o = cur_of;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int w = 0; w < 4; w++) begin
            sel = w;
            #0;
            n_checks++;
            if ({cur_ir, cur_ov, cur_sum, cur_co, cur_of} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got ir=%b ov=%b sum=%h co=%b of=%b need ir=1 ov=0 sum=00 co=0 of=0",
                         w, cur_ir, cur_ov, cur_sum, cur_co, cur_of);
            end
            $display("reset inst=%0d ir=%b ov=%b sum=%h", w, cur_ir, cur_ov, cur_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_step1();
        logic [7:0] va [0:3] = '{8'hFF, 8'h7F, 8'h80, 8'h12};
        logic [7:0] vb [0:3] = '{8'h01, 8'h01, 8'h80, 8'h34};
        logic       vc [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] es [0:3] = '{8'h00, 8'h80, 8'h00, 8'h47};
        logic       ec [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       eo [0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat; logic [7:0] s; logic c; logic o;
        for (int k = 0; k < 4; k++) begin
            run_op(0, va[k], vb[k], vc[k], lat, s, c, o);
            $display("add_s1 a=%h b=%h cin=%b -> lat=%0d sum=%h co=%b of=%b", va[k], vb[k], vc[k], lat, s, c, o);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL add_s1_latency got %0d need 8", lat);
            end
            n_checks++;
            if ({s, c, o} !== {es[k], ec[k], eo[k]}) begin
                n_fail++;
                $display("FAIL add_s1_result got sum=%h co=%b of=%b need sum=%h co=%b of=%b", s, c, o, es[k], ec[k], eo[k]);
            end
            release_result();
            n_checks++;
            if ({cur_ir, cur_ov} !== 2'b10) begin
                n_fail++;
                $display("FAIL add_s1_release got ir=%b ov=%b need ir=1 ov=0", cur_ir, cur_ov);
            end
        end
    endtask

    task automatic test_ignore_in_run();
        int lat;
        sel = 0;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        iv[0] = 1'b0;
        lat = 5;
        while (!cur_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("ignore_in_run lat=%0d sum=%h co=%b", lat, cur_sum, cur_co);
        n_checks++;
        if ({cur_ov, cur_sum, cur_co} !== {1'b1, 8'h46, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_in_run got ov=%b sum=%h co=%b need ov=1 sum=46 co=0", cur_ov, cur_sum, cur_co);
        end
        release_result();
    endtask

    task automatic test_hold_step4();
        int lat; logic [7:0] s; logic c; logic o;
        run_op(1, 8'h0F, 8'h00, 1'b1, lat, s, c, o);
        $display("hold_s4 a=0f b=00 cin=1 -> lat=%0d sum=%h co=%b of=%b", lat, s, c, o);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL hold_s4_latency got %0d need 2", lat);
        end
        n_checks++;
        if ({s, c, o} !== {8'h10, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_s4_result got sum=%h co=%b of=%b need sum=10 co=0 of=0", s, c, o);
        end
        for (int k = 0; k < 5; k++) begin
            iv[1] = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            @(negedge clk);
            $display("hold_s4 cycle=%0d ov=%b ir=%b sum=%h", k, cur_ov, cur_ir, cur_sum);
            n_checks++;
            if ({cur_ov, cur_ir, cur_sum, cur_co, cur_of} !== {1'b1, 1'b0, 8'h10, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_s4_stable cycle=%0d got ov=%b ir=%b sum=%h co=%b of=%b need ov=1 ir=0 sum=10 co=0 of=0",
                         k, cur_ov, cur_ir, cur_sum, cur_co, cur_of);
            end
        end
        iv[1] = 1'b0;
        release_result();
        n_checks++;
        if ({cur_ir, cur_ov} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_s4_release got ir=%b ov=%b need ir=1 ov=0", cur_ir, cur_ov);
        end
    endtask

    task automatic test_flush();
        int lat; logic [7:0] s; logic c; logic o; logic seen;
        sel = 0;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; c8 = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        $display("flush at cnt=3 -> ir=%b ov=%b sum=%h", cur_ir, cur_ov, cur_sum);
        n_checks++;
        if ({cur_ir, cur_ov, cur_sum} !== {1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL flush_to_idle got ir=%b ov=%b sum=%h need ir=1 ov=0 sum=00", cur_ir, cur_ov, cur_sum);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cur_ov) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_out_valid got out_valid seen=%b need 0", seen);
        end
        // flush together with in_valid in IDLE must not accept
        flush = 1'b1; iv[0] = 1'b1;
        @(negedge clk);
        flush = 1'b0; iv[0] = 1'b0;
        $display("flush+in_valid idle -> ir=%b", cur_ir);
        n_checks++;
        if (cur_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_blocks_accept got ir=%b need 1", cur_ir);
        end
        run_op(0, 8'h55, 8'h0F, 1'b0, lat, s, c, o);
        $display("after flush a=55 b=0f -> lat=%0d sum=%h co=%b of=%b", lat, s, c, o);
        n_checks++;
        if ({lat[7:0], s, c, o} !== {8'd8, 8'h64, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_next_op got lat=%0d sum=%h co=%b of=%b need lat=8 sum=64 co=0 of=0", lat, s, c, o);
        end
        release_result();
    endtask

    task automatic test_reset_midrun();
        int lat; logic [7:0] s; logic c; logic o;
        sel = 2;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h01; c8 = 1'b0; iv[2] = 1'b1;
        @(negedge clk);
        iv[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("s2 mid-run after 2 steps sum=%h ov=%b", cur_sum, cur_ov);
        n_checks++;
        if ({cur_ov, cur_sum} !== {1'b0, 8'h04}) begin
            n_fail++;
            $display("FAIL midrun_partial got ov=%b sum=%h need ov=0 sum=04", cur_ov, cur_sum);
        end
        #1 rst_n = 1'b0;
        #1;
        $display("s2 async reset ir=%b ov=%b sum=%h", cur_ir, cur_ov, cur_sum);
        n_checks++;
        if ({cur_ir, cur_ov, cur_sum, cur_co, cur_of} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrun_async_reset got ir=%b ov=%b sum=%h co=%b of=%b need ir=1 ov=0 sum=00 co=0 of=0",
                     cur_ir, cur_ov, cur_sum, cur_co, cur_of);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2, 8'hAA, 8'h55, 1'b1, lat, s, c, o);
        $display("s2 a=aa b=55 cin=1 -> lat=%0d sum=%h co=%b of=%b", lat, s, c, o);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL s2_latency got %0d need 4", lat);
        end
        n_checks++;
        if ({s, c, o} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL s2_result got sum=%h co=%b of=%b need sum=00 co=1 of=0", s, c, o);
        end
        release_result();
    endtask

    task automatic test_truth_table();
        int lat; logic [7:0] s; logic c; logic o;
        logic ta, tb, tc, es, ec, eo;
        for (int i = 0; i < 8; i++) begin
            ta = i[2]; tb = i[1]; tc = i[0];
            es = ta ^ tb ^ tc;
            ec = (ta & tb) | (ta & tc) | (tb & tc);
            eo = tc ^ ec;
            run_op(3, {7'b0, ta}, {7'b0, tb}, tc, lat, s, c, o);
            $display("w1 a=%b b=%b cin=%b -> lat=%0d sum=%b co=%b of=%b", ta, tb, tc, lat, s[0], c, o);
            n_checks++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL w1_latency row=%0d got %0d need 1", i, lat);
            end
            n_checks++;
            if ({s, c, o} !== {7'b0, es, ec, eo}) begin
                n_fail++;
                $display("FAIL w1_row row=%0d got sum=%b co=%b of=%b need sum=%b co=%b of=%b", i, s[0], c, o, es, ec, eo);
            end
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        int gap; int lat;
        sel = 0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; iv[0] = 1'b1; out_ready = 1'b1;
        lat = 0;
        while (!cur_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("b2b first result sum=%h after %0d cycles", cur_sum, lat);
        n_checks++;
        if ({cur_ov, cur_sum} !== {1'b1, 8'h30}) begin
            n_fail++;
            $display("FAIL b2b_first got ov=%b sum=%h need ov=1 sum=30", cur_ov, cur_sum);
        end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!cur_ov && gap < 30);
        iv[0] = 1'b0;
        $display("b2b issue interval=%0d sum=%h", gap, cur_sum);
        n_checks++;
        if ({gap[7:0], cur_sum} !== {8'd10, 8'h30}) begin
            n_fail++;
            $display("FAIL b2b_interval got gap=%0d sum=%h need gap=10 sum=30", gap, cur_sum);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        sel       = 0;
        rst_n     = 1'b1;
        iv        = 4'b0;
        a8        = 8'h00;
        b8        = 8'h00;
        c8        = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add_step1();
        test_ignore_in_run();
        test_hold_step4();
        test_flush();
        test_reset_midrun();
        test_truth_table();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
